// File: rtl/rf_port_arbiter_if.sv
// Register-file arbitration bundle: two requester field sets in, granted register-file controls out.
// Requesters drive the request side (master); the arbiter drives grants and datapath controls (slave).
interface rf_port_arbiter_if #(
  parameter int AW = 2
);
  // requester 0 (sequencing control FSM)
  logic          req0;
  logic          lock0;
  logic          we0;
  logic          src0;
  logic [AW-1:0] waddr0;
  logic [AW-1:0] raddr1_0;
  logic [AW-1:0] raddr2_0;

  // requester 1 (host/debug access port)
  logic          req1;
  logic          lock1;
  logic          we1;
  logic          src1;
  logic [AW-1:0] waddr1;
  logic [AW-1:0] raddr1_1;
  logic [AW-1:0] raddr2_1;

  // grants and register-file controls
  logic          gnt0;
  logic          gnt1;
  logic          rfwe;
  logic          rfsrcmuxsel;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          wr0_drop;

  modport master (
    output req0, lock0, we0, src0, waddr0, raddr1_0, raddr2_0,
    output req1, lock1, we1, src1, waddr1, raddr1_1, raddr2_1,
    input  gnt0, gnt1, rfwe, rfsrcmuxsel, waddr, raddr1, raddr2, wr0_drop
  );

  modport slave (
    input  req0, lock0, we0, src0, waddr0, raddr1_0, raddr2_0,
    input  req1, lock1, we1, src1, waddr1, raddr1_1, raddr2_1,
    output gnt0, gnt1, rfwe, rfsrcmuxsel, waddr, raddr1, raddr2, wr0_drop
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin register-file arbiter with bounded locking; grant registered one cycle after req.
// A requester waits (holds req and fields) until it sees its grant; writes to R0 are suppressed.
module rf_port_arbiter #(
  parameter int AW       = 2,
  parameter int MAX_LOCK = 4,
  parameter int CW       = 3
) (
  input  logic               clk,
  input  logic               reset,
  rf_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [CW-1:0] LOCK_LIM = CW'(MAX_LOCK - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_nxt;
  logic          wr0_drop_q;

  // owner's fields, selected by the current grant
  logic          own_req;
  logic          own_lock;
  logic          own_we;
  logic          own_src;
  logic [AW-1:0] own_waddr;
  logic [AW-1:0] own_raddr1;
  logic [AW-1:0] own_raddr2;
  logic          oth_req;
  logic          recent;
  logic          hold;
  logic          active;
  logic          wr0_hit;

  always_comb begin
    own_req    = 1'b0;
    own_lock   = 1'b0;
    own_we     = 1'b0;
    own_src    = 1'b0;
    own_waddr  = '0;
    own_raddr1 = '0;
    own_raddr2 = '0;
    oth_req    = 1'b0;
    case (state)
      G0: begin
        own_req    = bus.req0;
        own_lock   = bus.lock0;
        own_we     = bus.we0;
        own_src    = bus.src0;
        own_waddr  = bus.waddr0;
        own_raddr1 = bus.raddr1_0;
        own_raddr2 = bus.raddr2_0;
        oth_req    = bus.req1;
      end
      G1: begin
        own_req    = bus.req1;
        own_lock   = bus.lock1;
        own_we     = bus.we1;
        own_src    = bus.src1;
        own_waddr  = bus.waddr1;
        own_raddr1 = bus.raddr1_1;
        own_raddr2 = bus.raddr2_1;
        oth_req    = bus.req0;
      end
      default: ;
    endcase
  end

  // The current owner counts as the most recent grantee in the tie-break of this very cycle.
  always_comb begin
    recent = last;
    if (state == G0) recent = 1'b0;
    else if (state == G1) recent = 1'b1;
  end

  assign hold = (state != IDLE) && own_req && own_lock &&
                (!oth_req || (lock_cnt < LOCK_LIM));

  always_comb begin
    state_nxt    = IDLE;
    lock_cnt_nxt = '0;
    if (hold) begin
      state_nxt    = state;
      lock_cnt_nxt = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end else if (bus.req0 && bus.req1) begin
      state_nxt = recent ? G0 : G1;
    end else if (bus.req0) begin
      state_nxt = G0;
    end else if (bus.req1) begin
      state_nxt = G1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (state == G0) last <= 1'b0;
      else if (state == G1) last <= 1'b1;
    end
  end

  // A transaction runs only while the owner still requests; R0 is never written.
  assign active  = (state != IDLE) && own_req;
  assign wr0_hit = active && own_we && (own_waddr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr0_drop_q <= 1'b0;
    else       wr0_drop_q <= wr0_hit;
  end

  always_comb begin
    bus.gnt0        = (state == G0);
    bus.gnt1        = (state == G1);
    bus.rfwe        = 1'b0;
    bus.rfsrcmuxsel = 1'b0;
    bus.waddr       = '0;
    bus.raddr1      = '0;
    bus.raddr2      = '0;
    if (active) begin
      bus.rfwe        = own_we && (own_waddr != '0);
      bus.rfsrcmuxsel = own_src;
      bus.waddr       = own_waddr;
      bus.raddr1      = own_raddr1;
      bus.raddr2      = own_raddr2;
    end
  end

  assign bus.wr0_drop = wr0_drop_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed scenarios plus random traffic against an owner/streak reference model.
module tb_rf_port_arbiter;
  localparam int AW       = 2;
  localparam int MAX_LOCK = 4;
  localparam int CW       = 3;
  localparam int CNT_SAT  = (1 << CW) - 1;

  logic clk;
  logic reset;

  rf_port_arbiter_if #(.AW(AW)) bus ();

  rf_port_arbiter #(.AW(AW), .MAX_LOCK(MAX_LOCK), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // requester stimulus, index = requester number
  logic          req[2];
  logic          lock[2];
  logic          we[2];
  logic          src[2];
  logic [AW-1:0] wa[2];
  logic [AW-1:0] ra1[2];
  logic [AW-1:0] ra2[2];

  assign bus.req0 = req[0];  assign bus.req1 = req[1];
  assign bus.lock0 = lock[0]; assign bus.lock1 = lock[1];
  assign bus.we0 = we[0];    assign bus.we1 = we[1];
  assign bus.src0 = src[0];  assign bus.src1 = src[1];
  assign bus.waddr0 = wa[0]; assign bus.waddr1 = wa[1];
  assign bus.raddr1_0 = ra1[0]; assign bus.raddr1_1 = ra1[1];
  assign bus.raddr2_0 = ra2[0]; assign bus.raddr2_1 = ra2[1];

  int errors = 0;
  int checks = 0;

  // reference model: who owns the datapath, who owned it most recently, how long the lock has held
  int m_own;
  int m_last;
  int m_streak;
  bit m_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1; m_streak = 0; m_drop = 1'b0;
  endtask

  task automatic model_step();
    int o;
    bit keep;
    int nxt;
    o = m_own;
    keep = 1'b0;
    if (o >= 0) begin
      if (req[o] && lock[o] && (!req[1-o] || m_streak < MAX_LOCK - 1)) keep = 1'b1;
      m_drop = req[o] && we[o] && (wa[o] == 0);
      m_last = o;
    end else begin
      m_drop = 1'b0;
    end
    if (keep) begin
      nxt = o;
      m_streak = (m_streak < CNT_SAT) ? m_streak + 1 : CNT_SAT;
    end else begin
      if (req[0] && req[1]) nxt = 1 - m_last;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
      m_streak = 0;
    end
    m_own = nxt;
  endtask

  task automatic compare_all();
    int o;
    bit act;
    o = (m_own < 0) ? 0 : m_own;
    act = (m_own >= 0) && req[o];
    check_eq("gnt0", 32'(bus.gnt0), 32'(m_own == 0));
    check_eq("gnt1", 32'(bus.gnt1), 32'(m_own == 1));
    check_eq("rfwe", 32'(bus.rfwe), 32'(act && we[o] && (wa[o] != 0)));
    check_eq("rfsrcmuxsel", 32'(bus.rfsrcmuxsel), act ? 32'(src[o]) : 32'd0);
    check_eq("waddr", 32'(bus.waddr), act ? 32'(wa[o]) : 32'd0);
    check_eq("raddr1", 32'(bus.raddr1), act ? 32'(ra1[o]) : 32'd0);
    check_eq("raddr2", 32'(bus.raddr2), act ? 32'(ra2[o]) : 32'd0);
    check_eq("wr0_drop", 32'(bus.wr0_drop), 32'(m_drop));
  endtask

  // called at a falling edge with inputs already applied; returns at the next falling edge
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic r, input logic l, input logic w,
                         input logic s, input logic [AW-1:0] a);
    req[i] = r; lock[i] = l; we[i] = w; src[i] = s; wa[i] = a;
    ra1[i] = a + 2'd1; ra2[i] = a + 2'd2;
  endtask

  initial begin
    int streak;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check_eq("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check_eq("rst_rfwe", 32'(bus.rfwe), 32'd0);
    check_eq("rst_wr0_drop", 32'(bus.wr0_drop), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // requester 0 alone, writing R1
    set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    repeat (4) tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();

    // both unlocked -> alternate
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    set_req(1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    repeat (5) tick();
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();

    // requester 1 locks, requester 0 waits: four G1 cycles then G0
    set_req(1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    streak = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.gnt1) streak++;
      if (c == 4) check_eq("lock_release_gnt0", 32'(bus.gnt0), 32'd1);
      #0;
      tick();
    end
    check_eq("lock_streak", 32'(streak), 32'd4);
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();

    // requester 1 locks alone for 10 cycles, then requester 0 arrives
    set_req(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    repeat (11) tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();

    // write to R0 is suppressed and flagged
    set_req(0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    repeat (3) tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();

    // reset while G1 is writing
    set_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
    tick();
    #1;
    check_eq("pre_rst_rfwe", 32'(bus.rfwe), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_gnt1", 32'(bus.gnt1), 32'd0);
    check_eq("midrst_rfwe", 32'(bus.rfwe), 32'd0);
    check_eq("midrst_waddr", 32'(bus.waddr), 32'd0);
    check_eq("midrst_raddr1", 32'(bus.raddr1), 32'd0);
    check_eq("midrst_raddr2", 32'(bus.raddr2), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick();
    #1;
    check_eq("post_rst_tie_gnt0", 32'(bus.gnt0), 32'd1);
    #0;
    tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        lock[i] = ($urandom_range(0, 2) == 0);
        we[i]   = $urandom_range(0, 1) != 0;
        src[i]  = $urandom_range(0, 1) != 0;
        wa[i]   = AW'($urandom_range(0, 3));
        ra1[i]  = AW'($urandom_range(0, 3));
        ra2[i]  = AW'($urandom_range(0, 3));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
Two-requester arbiter sharing the register-file datapath (read ports raddr1/raddr2, write port waddr/rfwe, source mux rfsrcmuxsel) between the sequencing control FSM (requester 0) and a host/debug access port (requester 1). It grants one requester per cycle using round-robin with optional bounded locking. It drives the register-file control signals from the granted requester's fields. It also blocks writes to R0.

Parameters:
AW, 2, register address width (4 registers)
MAX_LOCK, 4, maximum consecutive locked grant cycles while the other requester is waiting (>=1)
CW, 3, lock counter width, must satisfy 2^CW > MAX_LOCK

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req0  in  1  requester 0 wants the datapath this cycle
lock0  in  1  requester 0 asks to keep the grant next cycle
we0  in  1  requester 0 write enable
src0  in  1  requester 0 rfsrcmuxsel value
waddr0  in  AW  requester 0 write address
raddr1_0  in  AW  requester 0 read address A
raddr2_0  in  AW  requester 0 read address B
req1, lock1, we1, src1, waddr1, raddr1_1, raddr2_1  in  (same widths)  requester 1 equivalents
gnt0  out  1  requester 0 owns the datapath this cycle
gnt1  out  1  requester 1 owns the datapath this cycle
rfwe  out  1  register-file write enable
rfsrcmuxsel  out  1  register-file source mux select
waddr  out  AW  register-file write address
raddr1  out  AW  register-file read address A
raddr2  out  AW  register-file read address B
wr0_drop  out  1  registered one-cycle pulse: a write to R0 was suppressed

Behaviour:
- States: IDLE, G0, G1, held in a state register. gnt0 = (state==G0), gnt1 = (state==G1). The grant is registered; there is no combinational path from req to gnt.
- Reset (asynchronous): state=IDLE, last=1 (requester 0 wins the first tie), lock_cnt=0, wr0_drop=0.
- Handshake: a transaction executes in any cycle where gnt_i=1 and req_i=1. A requester holds req and its fields stable until it observes gnt_i. Latency is one cycle from the first req to gnt when uncontended.
- Next-state evaluation, every cycle:
  - Hold: if state==Gi, req_i=1, lock_i=1, and (req_other=0 or lock_cnt < MAX_LOCK-1), stay in Gi and increment lock_cnt (saturate at 2^CW-1).
  - Otherwise arbitrate:
    - both req -> G(not last), where last is updated to the current owner whenever state is G0/G1;
    - only req0 -> G0;
    - only req1 -> G1;
    - none -> IDLE.
  - lock_cnt clears to 0 whenever the next state differs from the current state or the hold condition fails.
- An unlocked requester with continuous req and an idle peer is re-granted every cycle (back-to-back).
- Datapath outputs are combinational from state and the owner's fields:
  - In Gi with req_i=1: raddr1/raddr2/waddr/rfsrcmuxsel follow the owner's fields; rfwe = we_i & (waddr_i != 0).
  - In IDLE, or Gi with req_i=0 (owner dropped its request): all datapath outputs are 0.
- R0 protection: if the owner has req_i=1, we_i=1 and waddr_i=0, rfwe stays 0 and wr0_drop pulses high on the next cycle.
- Requester drops req while granted: no write that cycle, then re-arbitrate normally.
- Reset mid-transaction: outputs go to 0 immediately (asynchronous). A write in flight in that cycle is not guaranteed.

Test Plan:
- Reset, then req0=1 alone (we0=1, waddr0=1, src0=0) -> gnt0=1 from the next cycle; rfwe=1, waddr=1 while req0 held; gnt1 stays 0.
- req0 and req1 asserted in the same cycle after reset, both unlocked and held for 4 cycles -> grants alternate G0,G1,G0,G1.
- req1=1 with lock1=1 held, req0=1 from the same cycle, MAX_LOCK=4 -> gnt1 for exactly 4 cycles, then gnt0 in the 5th granted cycle.
- req1=1, lock1=1 with req0=0 for 10 cycles -> gnt1 held for all 10 cycles; lock_cnt saturates without wrap.
- req0, we0=1, waddr0=0 -> rfwe=0 while granted; wr0_drop=1 exactly one cycle later.
- Assert reset while in G1 with rfwe=1 -> gnt1, rfwe and all address outputs become 0 in the same cycle; after release, the first tie goes to requester 0.
